sequence_scan_scheduler: RTL and testbench
==========================================

// Module: sequence_scan_scheduler
// PURPOSE
//  Shares one serial "100" sequence detector between NUM_REQ parallel-word requesters.
//  Round-robin arbitration selects one requester, whose word is shifted MSB-first into the
//  detector. Matches are counted per word and returned on a valid/ready result port.
//  Sits between the word-producing front-ends and the match-statistics logic.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  WORD_W   8  bits per request word, shifted MSB first (>=3)
//  CNT_W    4  width of res_count; saturates at all-ones
// PORTS
//  clk        in   1               single clock, rising edge
//  reset      in   1               asynchronous, active-low; low = reset
//  req_valid  in   NUM_REQ         per-requester word valid
//  req_data   in   NUM_REQ*WORD_W  requester i word at [i*WORD_W +: WORD_W]
//  req_ready  out  NUM_REQ         one-hot grant; transfer when valid[i]&ready[i]
//  res_valid  out  1               result available
//  res_ready  in   1               result consumer accepts
//  res_id     out  $clog2(NUM_REQ) index of requester this result belongs to
//  res_count  out  CNT_W           number of "100" matches in the word
//  res_hit    out  1               res_count != 0
// BEHAVIOUR
//  Reset (reset low, async): FSM=IDLE, rr pointer=0, shift reg/count/bit counter=0,
//   detector state=00; req_ready=0, res_valid=0, res_id=0, res_count=0, res_hit=0.
//  FSM: IDLE -> SHIFT -> DRAIN -> REPORT -> IDLE.
//   IDLE: req_ready = one-hot of first valid requester at/after rr pointer (wraps).
//    All zero if no valid. On accept: latch word and id; count=0; detector cleared to 00;
//    rr pointer = granted id+1 mod NUM_REQ; go to SHIFT.
//   SHIFT: WORD_W cycles. Detector serial input = shreg MSB; shreg shifts left each cycle.
//    After WORD_W bits, go to DRAIN.
//   DRAIN: one cycle, so a match completed by the last bit is counted.
//   REPORT: res_valid=1; res_id/res_count/res_hit stable until res_valid&res_ready,
//    then IDLE. req_ready=0 in every state except IDLE.
//  Counting: in SHIFT and DRAIN, count += 1 every cycle detector out==1. Saturate at 2^CNT_W-1.
//  Detector (state, input 1 / input 0):
//   00->01/00, 01->01/10, 10->01/11, 11->01/00; out = (state==11).
//   Overlap: the trailing bits of one match never seed the next, except through state 11 -> 01 on a 1.
//  Latency: res_valid rises WORD_W+2 cycles after the accept cycle. With res_ready held high,
//   throughput is 1 word per WORD_W+3 cycles.
//  Boundaries: simultaneous valids are served strictly round-robin. A requester that drops
//   valid without a grant loses nothing. req_data is sampled only at accept.
//   A reset assertion mid-SHIFT/REPORT aborts the word with no result; the next grant after
//   reset starts from requester 0.
// STRUCTURE
//  Shared package seq_scan_pkg:
//   - state encodings ST_IDLE/ST_SHIFT/ST_DRAIN/ST_REPORT;
//   - detector state encodings DET_S0..DET_S3;
//   - clog2 helper.
//  Sub-module seq_detect_100: 2-bit detector FSM with
//   clk, reset (active-low async), clr (sync), en, serial_in, out.
//   It advances only when en=1; clr forces 00.
//  Arbiter, serializer, counter and FSM live in this module.
// TESTING
//  1. req0 word 8'b1001_0000, res_ready=1 -> res_id=0, res_count=2, res_hit=1;
//     res_valid at accept+10.
//  2. req1 word 8'h04 -> res_count=1 (match on last bit, exercises DRAIN).
//     req2 word 8'hFF -> res_count=0, res_hit=0.
//  3. All four valid constantly, words 8'hC9 -> grants 0,1,2,3,0 in order;
//     each res_count=2; exactly one req_ready bit high per accept.
//  4. Hold res_ready=0 for 20 cycles in REPORT -> res_valid and outputs stable,
//     req_ready all 0; result accepted on the cycle res_ready=1.
//  5. Assert reset low during SHIFT bit 4 -> all outputs 0 immediately.
//     No result after release; next grant goes to req0 when requesters 0 and 3 are valid.
//  6. CNT_W=1 build, word 8'b1001_0010 -> res_count saturates at 1, res_hit=1.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared encodings and helpers for the sequence scan scheduler and its "100" detector.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    DET_S0 = 2'b00,
    DET_S1 = 2'b01,
    DET_S2 = 2'b10,
    DET_S3 = 2'b11
  } det_state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/seq_detect_100.sv
// Serial "100" detector; advances only on en, clr returns it to the empty state.
//   state  | meaning
//   DET_S0 | no useful prefix seen
//   DET_S1 | last bit was 1
//   DET_S2 | last bits were 10
//   DET_S3 | last bits were 100 (match, out=1)
module seq_detect_100
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic serial_in,
  output logic out
);

  det_state_t st, st_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= DET_S0;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (clr) begin
      st_nxt = DET_S0;
    end else if (en) begin
      if (serial_in) begin
        st_nxt = DET_S1;
      end else begin
        case (st)
          DET_S0:  st_nxt = DET_S0;
          DET_S1:  st_nxt = DET_S2;
          DET_S2:  st_nxt = DET_S3;
          default: st_nxt = DET_S0;
        endcase
      end
    end
  end

  assign out = (st == DET_S3);

endmodule

// File: rtl/sequence_scan_scheduler.sv
// Round-robin shares one serial "100" detector among NUM_REQ word requesters and
// returns a saturating per-word match count on a valid/ready result port.
//   state     | meaning
//   ST_IDLE   | offer grant to next valid requester, accept word
//   ST_SHIFT  | shift WORD_W bits MSB-first into the detector
//   ST_DRAIN  | one extra cycle to count a match finished by the last bit
//   ST_REPORT | hold result until res_ready
module sequence_scan_scheduler
  import seq_scan_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WORD_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [clog2(NUM_REQ)-1:0]   res_id,
  output logic [CNT_W-1:0]            res_count,
  output logic                        res_hit
);

  localparam int ID_W = clog2(NUM_REQ);
  localparam int BC_W = clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_t state, state_nxt;

  logic [ID_W-1:0]    rr_ptr, grant_id, id_q;
  logic [NUM_REQ-1:0] grant_vec;
  logic               grant_any;
  logic [WORD_W-1:0]  grant_word;
  logic [WORD_W-1:0]  shreg;
  logic [BC_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]   count;
  logic               accept, det_out;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    idx        = 0;
    grant_vec  = '0;
    grant_id   = '0;
    grant_any  = 1'b0;
    grant_word = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any      = 1'b1;
        grant_id       = ID_W'(idx);
        grant_vec[idx] = 1'b1;
        grant_word     = req_data[idx*WORD_W +: WORD_W];
      end
    end
  end

  assign accept = (state == ST_IDLE) && grant_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_any) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (bit_cnt == '0) state_nxt = ST_DRAIN;
      ST_DRAIN:  state_nxt = ST_REPORT;
      ST_REPORT: if (res_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    res_valid = 1'b0;
    res_id    = '0;
    res_count = '0;
    res_hit   = 1'b0;
    case (state)
      ST_IDLE: req_ready = grant_vec;
      ST_REPORT: begin
        res_valid = 1'b1;
        res_id    = id_q;
        res_count = count;
        res_hit   = (count != '0);
      end
      default: ;
    endcase
  end

  // bit_cnt is a down-counter; reaching zero in SHIFT marks the last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      id_q    <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      count   <= '0;
    end else if (accept) begin
      rr_ptr  <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      id_q    <= grant_id;
      shreg   <= grant_word;
      bit_cnt <= BC_W'(WORD_W - 1);
      count   <= '0;
    end else begin
      if (state == ST_SHIFT) begin
        shreg <= {shreg[WORD_W-2:0], 1'b0};
        if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
      end
      if ((state == ST_SHIFT || state == ST_DRAIN) && det_out && count != CNT_MAX)
        count <= count + 1'b1;
    end
  end

  seq_detect_100 u_det (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept),
    .en        (state == ST_SHIFT),
    .serial_in (shreg[WORD_W-1]),
    .out       (det_out)
  );

endmodule

// File: tb/tb_sequence_scan_scheduler.sv
// Scoreboard bench: accepts push the model's expected result, a monitor pops on each result handshake.
module tb_sequence_scan_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [1:0]     res_id;
  logic [C-1:0]   res_count;
  logic           res_hit;

  // second build with a 1-bit saturating count
  logic [N-1:0]   v6 = '0;
  logic [N*W-1:0] d6 = '0;
  logic [N-1:0]   rdy6;
  logic           rv6;
  logic [1:0]     id6;
  logic [0:0]     cnt6;
  logic           hit6;

  always #5 clk = ~clk;

  sequence_scan_scheduler #(.NUM_REQ(N), .WORD_W(W), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_count(res_count), .res_hit(res_hit)
  );

  sequence_scan_scheduler #(.NUM_REQ(N), .WORD_W(W), .CNT_W(1)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(v6), .req_data(d6),
    .req_ready(rdy6), .res_valid(rv6), .res_ready(1'b1),
    .res_id(id6), .res_count(cnt6), .res_hit(hit6)
  );

  typedef struct { int id; int count; int acc; } exp_t;
  exp_t exp_q[$];
  int   grant_log[$];
  int   checks = 0, errors = 0, cyc = 0, mptr = 0, rise_cyc = 0;
  logic prev_rv = 1'b0, prev_rr = 1'b0, prev_hit = 1'b0;
  logic [1:0]   prev_id = '0;
  logic [C-1:0] prev_cnt = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Number of "100" substrings read MSB-first, clipped at cmax.
  function automatic int ref_count(input logic [W-1:0] w, input int cmax);
    int n = 0;
    for (int i = W - 1; i >= 2; i--)
      if (w[i] && !w[i-1] && !w[i-2]) n++;
    return (n > cmax) ? cmax : n;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    int   g, actual;
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      mptr    = 0;
      prev_rv = 1'b0;
      prev_rr = 1'b0;
    end else begin
      cyc++;
      if (req_ready != '0) begin
        g = rr_pick(req_valid, mptr);
        chk("grant_onehot", req_ready, (g < 0) ? 0 : (1 << g));
        actual = -1;
        for (int k = 0; k < N; k++) if (req_ready[k]) actual = k;
        grant_log.push_back(actual);
        if (g >= 0) begin
          e.id    = g;
          e.count = ref_count(req_data[g*W +: W], (1 << C) - 1);
          e.acc   = cyc;
          exp_q.push_back(e);
          mptr = (g + 1) % N;
        end
      end
      if (prev_rv && !prev_rr) begin
        chk("res_valid_held", res_valid, 1);
        if (res_valid) begin
          chk("res_id_stable", res_id, prev_id);
          chk("res_count_stable", res_count, prev_cnt);
          chk("res_hit_stable", res_hit, prev_hit);
        end
      end
      if (res_valid) begin
        if (!prev_rv) rise_cyc = cyc;
        chk("req_ready_in_report", req_ready, 0);
        if (res_ready) begin
          chk("unexpected_result", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("res_id", res_id, e.id);
            chk("res_count", res_count, e.count);
            chk("res_hit", res_hit, e.count != 0);
            chk("latency", rise_cyc - e.acc, W + 2);
          end
        end
      end
      prev_rv  = res_valid;
      prev_rr  = res_ready;
      prev_id  = res_id;
      prev_cnt = res_count;
      prev_hit = res_hit;
    end
  end

  task automatic wait_acc(input int i);
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    chk("accept_wait", ok, 1);
  endtask

  task automatic send(input int i, input logic [W-1:0] w);
    req_valid[i]     = 1'b1;
    req_data[i*W +: W] = w;
    wait_acc(i);
  endtask

  task automatic drain();
    bit ok = 0;
    res_ready = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !res_valid) ok = 1;
    end
    chk("drain", ok, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok, saw;
    int base;
    logic [N-1:0] acc;

    repeat (3) @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_hit", res_hit, 0);
    reset = 1'b1;

    // saturation build: two matches clip to 1
    v6 = 4'b0001;
    d6[7:0] = 8'b1001_0010;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin @(negedge clk); if (rdy6[0]) ok = 1; end
    @(posedge clk); #1 v6 = '0;
    chk("sat_accept", ok, 1);
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin @(negedge clk); if (rv6) ok = 1; end
    chk("sat_valid", ok, 1);
    chk("sat_count", cnt6, 1);
    chk("sat_hit", hit6, 1);
    chk("sat_id", id6, 0);
    @(posedge clk); #1;

    res_ready = 1'b1;
    send(0, 8'b1001_0000);
    drain();
    send(1, 8'h04);
    drain();
    send(2, 8'hFF);
    drain();

    // all four valid from reset: strict rotation 0,1,2,3,0
    pulse_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'hC9;
    base = grant_log.size();
    req_valid = '1;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk);
      if (grant_log.size() >= base + 5) ok = 1;
    end
    #1 req_valid = '0;
    chk("rr_five_grants", ok, 1);
    for (int k = 0; k < 5; k++) chk("rr_order", grant_log[base + k], k % N);
    drain();

    // consumer stalls in REPORT while another requester waits
    res_ready = 1'b0;
    send(1, 8'($urandom));
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin @(negedge clk); if (res_valid) ok = 1; end
    chk("stall_res_valid", ok, 1);
    @(posedge clk); #1;
    req_valid[3] = 1'b1;
    req_data[3*W +: W] = 8'($urandom);
    repeat (20) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", res_valid, 0);
    wait_acc(3);
    drain();

    // reset during SHIFT bit 4 aborts the word
    send(1, 8'b1001_1001);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_res_id", res_id, 0);
    chk("abort_res_count", res_count, 0);
    chk("abort_res_hit", res_hit, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    saw = 0;
    for (int k = 0; k < 15; k++) begin @(negedge clk); if (res_valid) saw = 1; end
    chk("no_result_after_reset", saw, 0);
    @(posedge clk); #1;
    req_data[0 +: W]   = 8'($urandom);
    req_data[3*W +: W] = 8'($urandom);
    req_valid = 4'b1001;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin @(negedge clk); if (req_ready != '0) ok = 1; end
    chk("post_reset_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_acc(3);
    drain();

    // randomized traffic: sticky valids, occasional withdrawals, random back-pressure
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_data[i*W +: W] = 8'($urandom);
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*W +: W] = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 req_valid = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
